// File: rtl/imm_pkg.sv
// Shared types and helpers for the immediate split path.
package imm_pkg;

  localparam int unsigned IMM_W      = 12;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned MAX_CHUNKS = (WORD_W + IMM_W - 1) / IMM_W;

  typedef logic [IMM_W-1:0] imm12_t;

  typedef enum logic [0:0] {
    IDLE,
    EMIT
  } split_state_t;

  // Minimal number of chunks (1..3) that rebuild value after sign/zero extension.
  function automatic logic [1:0] imm_chunk_count(input logic [WORD_W-1:0] value,
                                                 input logic              signed_mode);
    logic [1:0] n;
    if (signed_mode) begin
      if ((value[31:11] == '0) || (value[31:11] == '1)) begin
        n = 2'd1;
      end else if ((value[31:23] == '0) || (value[31:23] == '1)) begin
        n = 2'd2;
      end else begin
        n = 2'(MAX_CHUNKS);
      end
    end else begin
      if (value[31:12] == '0) begin
        n = 2'd1;
      end else if (value[31:24] == '0) begin
        n = 2'd2;
      end else begin
        n = 2'(MAX_CHUNKS);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/imm_fit_check.sv
// Combinational chunk-count computation for an incoming value.
module imm_fit_check
  import imm_pkg::*;
(
  input  logic [WORD_W-1:0] value,
  input  logic              signed_mode,
  output logic [1:0]        count,
  output logic              fits
);

  // Count comes straight from the shared helper so the model and RTL agree by construction.
  always_comb begin
    count = imm_chunk_count(value, signed_mode);
    fits  = (count == 2'd1);
  end

endmodule

// File: rtl/imm_split_unit.sv
// Splits a 32-bit constant into the minimal stream of 12-bit immediate chunks.
// Optional macro IMM_SPLIT_STATS_EN adds stat_fit/stat_split acceptance counters.
module imm_split_unit
  import imm_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CHUNK_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_value,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CHUNK_W-1:0] out_imm12,
  output logic [1:0]         out_idx,
  output logic               out_last,
`ifdef IMM_SPLIT_STATS_EN
  output logic [15:0]        stat_fit,
  output logic [15:0]        stat_split,
`endif
  output logic               out_fits
);

  split_state_t       state_q, state_d;
  logic [DATA_W-1:0]  value_q, value_d;
  logic               signed_q, signed_d;
  logic [1:0]         n_q, n_d;
  logic [1:0]         idx_q, idx_d;
  logic [1:0]         in_count;
  logic               in_fits;
  logic               emit;
  logic               last;
  logic               accept;
  logic [CHUNK_W-1:0] chunk;

  imm_fit_check u_fit_check (
    .value       (in_value),
    .signed_mode (in_signed),
    .count       (in_count),
    .fits        (in_fits)
  );

  // Handshake decode; in_ready reopens on the final chunk so N=1 values stream at full rate.
  always_comb begin
    emit     = (state_q == EMIT);
    last     = emit && (idx_q == 2'(n_q - 2'd1));
    in_ready = !reset && (!emit || (out_ready && last));
    accept   = in_valid && in_ready;
  end

  // Select the current chunk from registered state only.
  always_comb begin
    chunk = '0;
    unique case (idx_q)
      2'd0:    chunk = value_q[11:0];
      2'd1:    chunk = value_q[23:12];
      default: chunk = {{4{signed_q & value_q[31]}}, value_q[31:24]};
    endcase
  end

  // Outputs are forced to zero outside EMIT so idle/reset values are clean.
  always_comb begin
    out_valid = emit;
    out_imm12 = emit ? chunk : '0;
    out_idx   = emit ? idx_q : 2'd0;
    out_last  = last;
    out_fits  = emit && (n_q == 2'd1);
  end

  // Next-state: a new load takes priority, which also covers the chained final handshake.
  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    signed_d = signed_q;
    n_d      = n_q;
    idx_d    = idx_q;
    if (accept) begin
      state_d  = EMIT;
      value_d  = in_value;
      signed_d = in_signed;
      n_d      = in_count;
      idx_d    = 2'd0;
    end else if (emit && out_ready) begin
      if (last) begin
        state_d = IDLE;
        idx_d   = 2'd0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      value_q  <= '0;
      signed_q <= 1'b0;
      n_q      <= 2'd1;
      idx_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      signed_q <= signed_d;
      n_q      <= n_d;
      idx_q    <= idx_d;
    end
  end

`ifdef IMM_SPLIT_STATS_EN
  logic [15:0] stat_fit_q, stat_split_q;

  // Saturating acceptance counters, split by whether the value fit one chunk.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fit_q   <= '0;
      stat_split_q <= '0;
    end else if (accept) begin
      if (in_fits) begin
        if (stat_fit_q != 16'hFFFF) stat_fit_q <= stat_fit_q + 16'd1;
      end else begin
        if (stat_split_q != 16'hFFFF) stat_split_q <= stat_split_q + 16'd1;
      end
    end
  end

  assign stat_fit   = stat_fit_q;
  assign stat_split = stat_split_q;
`endif

endmodule

// File: tb/tb_imm_split_unit.sv
// Directed bench for imm_split_unit: vector table plus backpressure, chaining and reset cases.
module tb_imm_split_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        in_signed;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_imm12;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        out_fits;

  int checks   = 0;
  int failures = 0;
  int sb_fit   = 0;
  int sb_split = 0;

  always #5 clk = ~clk;

`ifdef IMM_SPLIT_STATS_EN
  logic [15:0] stat_fit, stat_split;
  imm_split_unit dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .in_signed  (in_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm12  (out_imm12),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .stat_fit   (stat_fit),
    .stat_split (stat_split),
    .out_fits   (out_fits)
  );
`else
  imm_split_unit dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_signed (in_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm12 (out_imm12),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_fits  (out_fits)
  );
`endif

  typedef struct {
    logic [31:0]       value;
    logic              sgn;
    int                n;
    logic [2:0][11:0]  c;  // {chunk2, chunk1, chunk0}
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s tag=%0d got=%h expected=%h", name, tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_accept(input int n);
    if (n == 1) sb_fit++;
    else sb_split++;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    vecs[0]  = '{32'h0000_07FF, 1'b1, 1, {12'h000, 12'h000, 12'h7FF}};
    vecs[1]  = '{32'hFFFF_F800, 1'b1, 1, {12'h000, 12'h000, 12'h800}};
    vecs[2]  = '{32'hFFFF_F800, 1'b0, 3, {12'h0FF, 12'hFFF, 12'h800}};
    vecs[3]  = '{32'h0000_0800, 1'b1, 2, {12'h000, 12'h000, 12'h800}};
    vecs[4]  = '{32'h1234_5678, 1'b0, 3, {12'h012, 12'h345, 12'h678}};
    vecs[5]  = '{32'h8000_0000, 1'b1, 3, {12'hF80, 12'h000, 12'h000}};
    vecs[6]  = '{32'h0000_0000, 1'b0, 1, {12'h000, 12'h000, 12'h000}};
    vecs[7]  = '{32'hFFFF_FFFF, 1'b1, 1, {12'h000, 12'h000, 12'hFFF}};
    vecs[8]  = '{32'h0000_0FFF, 1'b0, 1, {12'h000, 12'h000, 12'hFFF}};
    vecs[9]  = '{32'h00FF_FFFF, 1'b0, 2, {12'h000, 12'hFFF, 12'hFFF}};
    vecs[10] = '{32'hFF80_0000, 1'b1, 2, {12'h000, 12'h800, 12'h000}};

    reset = 1'b1; in_valid = 1'b0; in_value = '0; in_signed = 1'b0; out_ready = 1'b0;
    step();
    chk("reset_in_ready", 0, 32'(in_ready), 32'd0);
    chk("reset_out_valid", 0, 32'(out_valid), 32'd0);
    chk("reset_out_imm12", 0, 32'(out_imm12), 32'd0);
    chk("reset_out_idx", 0, 32'(out_idx), 32'd0);
    chk("reset_out_last", 0, 32'(out_last), 32'd0);
    chk("reset_out_fits", 0, 32'(out_fits), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", 0, 32'(in_ready), 32'd1);

    // Table-driven vectors, consumer always ready.
    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      chk("vec_in_ready", i, 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_value = v.value; in_signed = v.sgn; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      count_accept(v.n);
      for (int k = 0; k < v.n; k++) begin
        chk("vec_out_valid", i * 10 + k, 32'(out_valid), 32'd1);
        chk("vec_imm12", i * 10 + k, 32'(out_imm12), 32'(v.c[k]));
        chk("vec_idx", i * 10 + k, 32'(out_idx), 32'(k));
        chk("vec_last", i * 10 + k, 32'(out_last), 32'(k == v.n - 1));
        chk("vec_fits", i * 10 + k, 32'(out_fits), 32'(v.n == 1));
        if (k != v.n - 1) chk("vec_in_ready_busy", i * 10 + k, 32'(in_ready), 32'd0);
        step();
      end
      chk("vec_done_valid", i, 32'(out_valid), 32'd0);
    end

    // Backpressure on idx1 of 0x1234_5678 unsigned.
    in_valid = 1'b1; in_value = 32'h1234_5678; in_signed = 1'b0; out_ready = 1'b1;
    step();
    count_accept(3);
    in_value = 32'h0000_0001;  // keep in_valid high: must not be accepted mid-value
    chk("bp_idx0", 0, 32'(out_imm12), 32'h678);
    step();
    chk("bp_idx1", 0, 32'(out_idx), 32'd1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_imm", k, 32'(out_imm12), 32'h345);
      chk("bp_hold_idx", k, 32'(out_idx), 32'd1);
      chk("bp_hold_last", k, 32'(out_last), 32'd0);
      chk("bp_hold_fits", k, 32'(out_fits), 32'd0);
      chk("bp_hold_valid", k, 32'(out_valid), 32'd1);
      chk("bp_in_ready", k, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_idx2_imm", 0, 32'(out_imm12), 32'h012);
    chk("bp_idx2_last", 0, 32'(out_last), 32'd1);
    step();
    chk("bp_done_valid", 0, 32'(out_valid), 32'd0);

    // Back-to-back N=1 values: one chunk per cycle, no idle gaps.
    in_valid = 1'b1; in_signed = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_value = 32'(k * 3 + 1);
      chk("b2b_in_ready", k, 32'(in_ready), 32'd1);
      step();
      count_accept(1);
      chk("b2b_valid", k, 32'(out_valid), 32'd1);
      chk("b2b_imm", k, 32'(out_imm12), 32'(k * 3 + 1));
      chk("b2b_last", k, 32'(out_last), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("b2b_done_valid", 0, 32'(out_valid), 32'd0);

`ifdef IMM_SPLIT_STATS_EN
    chk("stat_fit", 0, 32'(stat_fit), 32'(sb_fit));
    chk("stat_split", 0, 32'(stat_split), 32'(sb_split));
`endif

    // Reset during idx1 of a 3-chunk value drops it.
    in_valid = 1'b1; in_value = 32'h1234_5678; in_signed = 1'b0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("rst_mid_idx1", 0, 32'(out_idx), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_in_ready_during", 0, 32'(in_ready), 32'd0);
    step();
    reset = 1'b0;
    sb_fit = 0; sb_split = 0;
    #1;
    chk("rst_mid_valid", 0, 32'(out_valid), 32'd0);
    chk("rst_mid_imm", 0, 32'(out_imm12), 32'd0);
    chk("rst_mid_in_ready", 0, 32'(in_ready), 32'd1);
    step();
    chk("rst_mid_no_more", 0, 32'(out_valid), 32'd0);

    // One more value after reset so counters restart from zero.
    in_valid = 1'b1; in_value = 32'h0000_0800; in_signed = 1'b1;
    step();
    in_valid = 1'b0;
    count_accept(2);
    chk("post_rst_imm0", 0, 32'(out_imm12), 32'h800);
    step();
    chk("post_rst_imm1", 0, 32'(out_imm12), 32'h000);
    chk("post_rst_last", 0, 32'(out_last), 32'd1);
    step();

`ifdef IMM_SPLIT_STATS_EN
    chk("stat_fit_post_rst", 0, 32'(stat_fit), 32'(sb_fit));
    chk("stat_split_post_rst", 0, 32'(stat_split), 32'(sb_split));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
